// File: rtl/mem_access_ctrl.sv
// Main-memory port controller: round-robin arbitration between instruction
// fetch (requester 0) and execute (requester 1), then MAR/MDR/RAM strobe sequencing.
module mem_access_ctrl #(
  parameter int RAM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] req_we,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       write_to_MM,
  output logic       read_from_MM
);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 15) begin : gBadLatency
    $error("mem_access_ctrl: RAM_LATENCY must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WSTART = 3'd2,
    WHOLD  = 3'd3,
    RWAIT  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(RAM_LATENCY - 1);
  localparam logic [3:0] LAT_M2 = 4'(RAM_LATENCY - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lg_q, lg_d;
  logic       we_q, we_d;
  logic [1:0] grant_q, grant_d;
  logic       owner;

  // On a tie the requester that did not win last time gets the port.
  assign owner = (req == 2'b11) ? ~lg_q : req[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lg_q    <= 1'b1;
      we_q    <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lg_q    <= lg_d;
      we_q    <= we_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lg_d    = lg_q;
    we_d    = we_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d = owner ? 2'b10 : 2'b01;
          we_d    = req_we[owner];
          lg_d    = owner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (we_q) begin
          state_d = WSTART;
        end else begin
          cnt_d   = LAT_M1;
          state_d = RWAIT;
        end
      end
      WSTART: begin
        if (RAM_LATENCY == 1) begin
          state_d = DONE;
        end else begin
          cnt_d   = LAT_M2;
          state_d = WHOLD;
        end
      end
      WHOLD, RWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode from state only, so an async reset clears them at once.
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign MAR_in       = (state_q == ADDR);
  assign MDR_in       = (state_q == WSTART);
  assign write_to_MM  = (state_q == WSTART) || (state_q == WHOLD);
  assign read_from_MM = (state_q == RWAIT);
  assign MDR_out      = (state_q == DONE) && !we_q;
  assign done         = (state_q == DONE) ? grant_q : 2'b00;

endmodule
